// File: rtl/spi_flash_reader.sv
// spi_flash_reader
// Sequencer that sits upstream of a byte-level SPI engine. On a start request
// it holds the engine enabled (CS low) and sends the read opcode and the
// address, MSB first. It then clocks dummy 8'h00 bytes and streams each
// received byte out on a valid/ready interface. Backpressure is lossless:
// while the consumer stalls, SCK idles and CS stays low.
//
// Optional feature macro: FLASH_FAST_READ_EN
//   defined   : opcode 8'h0B followed by one 8'h00 dummy byte after the address
//   undefined : opcode READ_CMD, no dummy byte
module spi_flash_reader #(
    parameter int         ADDR_W   = 24,
    parameter int         LEN_W    = 16,
    parameter logic [7:0] READ_CMD = 8'h03
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  length,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done,
    output logic              busy_out,
    output logic              spi_enabled,
    output logic [7:0]        spi_data_in,
    output logic              spi_continue_read,
    input  logic [7:0]        spi_data_out,
    input  logic              spi_busy
);

    localparam int NA = ADDR_W / 8;

`ifdef FLASH_FAST_READ_EN
    localparam logic [7:0] CMD = 8'h0B;
    localparam int         HDR = NA + 2;
`else
    localparam logic [7:0] CMD = READ_CMD;
    localparam int         HDR = NA + 1;
`endif

    // Wide enough to hold HDR itself, which marks the data phase
    localparam int IW = $clog2(HDR + 1);

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        KICK,
        WAIT_HI,
        WAIT_LO,
        PRESENT,
        FINISH
    } state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [LEN_W-1:0]  rem_reg;
    // Index of the byte currently on the wire; saturates at HDR in the data phase
    logic [IW-1:0]     idx_reg;

    logic [HDR-1:0][7:0] hdr_bytes;
    logic [IW-1:0]       idx_next;
    logic [7:0]          tx_next;

    // Header byte table: opcode, address bytes MSB first, optional dummy byte
    assign hdr_bytes[0] = CMD;
    generate
        for (genvar gi = 0; gi < NA; gi++) begin : g_addr_bytes
            assign hdr_bytes[gi + 1] = addr_reg[ADDR_W - 1 - 8 * gi -: 8];
        end
`ifdef FLASH_FAST_READ_EN
        for (genvar gi = NA + 1; gi < HDR; gi++) begin : g_dummy_bytes
            assign hdr_bytes[gi] = 8'h00;
        end
`endif
    endgenerate

    assign idx_next = idx_reg + IW'(1);

    // Byte to shift out next: remaining header byte, or 8'h00 once reading data
    always_comb begin
        tx_next = 8'h00;
        for (int i = 0; i < HDR; i++) begin
            if (idx_next == IW'(i)) begin
                tx_next = hdr_bytes[i];
            end
        end
    end

    // Transaction sequencer with registered outputs
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_reg         <= IDLE;
            addr_reg          <= '0;
            rem_reg           <= '0;
            idx_reg           <= '0;
            out_data          <= 8'h00;
            out_valid         <= 1'b0;
            done              <= 1'b0;
            busy_out          <= 1'b0;
            spi_enabled       <= 1'b0;
            spi_data_in       <= 8'h00;
            spi_continue_read <= 1'b0;
        end else begin
            // Single-cycle strobes
            spi_continue_read <= 1'b0;
            done              <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (start) begin
                        busy_out <= 1'b1;
                        if (length != '0) begin
                            addr_reg    <= start_addr;
                            rem_reg     <= length;
                            idx_reg     <= '0;
                            spi_enabled <= 1'b1;
                            spi_data_in <= CMD;
                            state_reg   <= FIRST;
                        end else begin
                            // Zero-length request: report completion without touching CS
                            done      <= 1'b1;
                            state_reg <= FINISH;
                        end
                    end
                end

                // The engine starts the opcode byte from the enable edge alone
                FIRST: begin
                    state_reg <= WAIT_HI;
                end

                // continue_read was raised on entry; it drops by default here
                KICK: begin
                    state_reg <= WAIT_HI;
                end

                WAIT_HI: begin
                    if (spi_busy) begin
                        state_reg <= WAIT_LO;
                    end
                end

                WAIT_LO: begin
                    if (!spi_busy) begin
                        if (idx_reg < IW'(HDR)) begin
                            // Header byte finished; its received data is meaningless
                            idx_reg           <= idx_next;
                            spi_data_in       <= tx_next;
                            spi_continue_read <= 1'b1;
                            state_reg         <= KICK;
                        end else begin
                            out_data  <= spi_data_out;
                            out_valid <= 1'b1;
                            state_reg <= PRESENT;
                        end
                    end
                end

                // Hold the byte until accepted; SCK stays idle meanwhile
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        rem_reg   <= rem_reg - LEN_W'(1);
                        if (rem_reg == LEN_W'(1)) begin
                            spi_enabled <= 1'b0;
                            done        <= 1'b1;
                            state_reg   <= FINISH;
                        end else begin
                            spi_data_in       <= 8'h00;
                            spi_continue_read <= 1'b1;
                            state_reg         <= KICK;
                        end
                    end
                end

                // CS is high for this cycle, guaranteeing minimum deselect time
                FINISH: begin
                    busy_out    <= 1'b0;
                    spi_enabled <= 1'b0;
                    spi_data_in <= 8'h00;
                    state_reg   <= IDLE;
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb_spi_flash_reader
// Directed bench for spi_flash_reader. It models the byte-level SPI engine
// together with a flash that returns addr[7:0]^8'hA5 for each streamed byte.
// Honours FLASH_FAST_READ_EN the same way as the design.
module tb_spi_flash_reader;

`ifdef FLASH_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] CMD = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] CMD = 8'h03;
`endif

    logic        clk_in = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [23:0] start_addr = '0;
    logic [15:0] length = '0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        done;
    logic        busy_out;
    logic        spi_enabled;
    logic [7:0]  spi_data_in;
    logic        spi_continue_read;
    logic [7:0]  spi_data_out = 8'h00;
    logic        spi_busy = 1'b0;

    int passes = 0;
    int total  = 0;

    spi_flash_reader #(.ADDR_W(24), .LEN_W(16), .READ_CMD(8'h03)) dut (
        .clk_in            (clk_in),
        .reset             (reset),
        .start             (start),
        .start_addr        (start_addr),
        .length            (length),
        .out_data          (out_data),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .done              (done),
        .busy_out          (busy_out),
        .spi_enabled       (spi_enabled),
        .spi_data_in       (spi_data_in),
        .spi_continue_read (spi_continue_read),
        .spi_data_out      (spi_data_out),
        .spi_busy          (spi_busy)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- engine + flash model ----------------
    logic       eng_started = 1'b0;
    logic [3:0] eng_cnt = 4'd0;
    int         eng_k = 0;
    int         eng_starts = 0;
    logic [7:0] sess_log [0:15];

    function automatic logic [7:0] flash_byte(input int k);
        logic [23:0] a;
        if (k < HDR) return 8'h77;
        a = {sess_log[1], sess_log[2], sess_log[3]} + 24'(k - HDR);
        return a[7:0] ^ 8'hA5;
    endfunction

    // Engine: a byte takes 16 busy cycles; first byte starts on enable, later on continue_read
    always @(posedge clk_in) begin
        if (reset || !spi_enabled) begin
            spi_busy    <= 1'b0;
            eng_started <= 1'b0;
            eng_k       <= 0;
        end else if (!spi_busy) begin
            if (!eng_started || spi_continue_read) begin
                spi_busy    <= 1'b1;
                eng_cnt     <= 4'd15;
                eng_started <= 1'b1;
                if (eng_k < 16) sess_log[eng_k[3:0]] <= spi_data_in;
                eng_starts  <= eng_starts + 1;
            end
        end else if (eng_cnt == 4'd0) begin
            spi_busy     <= 1'b0;
            spi_data_out <= flash_byte(eng_k);
            eng_k        <= eng_k + 1;
        end else begin
            eng_cnt <= eng_cnt - 4'd1;
        end
    end

    // ---------------- output monitor ----------------
    int         mon_cnt = 0;
    int         done_tot = 0;
    int         en_tot = 0;
    logic [7:0] mon_log [0:255];

    // Inputs change just after posedge, so negedge values are what the next edge sees
    always @(negedge clk_in) begin
        if (out_valid && out_ready) begin
            mon_log[mon_cnt[7:0]] <= out_data;
            mon_cnt <= mon_cnt + 1;
        end
        if (done) done_tot <= done_tot + 1;
        if (spi_enabled) en_tot <= en_tot + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic pulse_start(input logic [23:0] a, input logic [15:0] l);
        start_addr = a;
        length     = l;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        total++;
        if ({out_valid, done, busy_out, spi_enabled, spi_continue_read} !== 5'b0) begin
            $display("FAIL reset_ctrl got=%b exp=00000", {out_valid, done, busy_out, spi_enabled, spi_continue_read});
        end else passes++;
        total++;
        if ({out_data, spi_data_in} !== 16'h0000) begin
            $display("FAIL reset_data got=%h exp=0000", {out_data, spi_data_in});
        end else passes++;
        $display("test_reset: done");
    endtask

    task automatic test_basic();
        logic [7:0] exp_out [0:3];
        logic [7:0] exp_mosi [0:HDR+3];
        int  m0, d0;
        bit  ok;
        exp_out = '{8'hE0, 8'hE3, 8'hE2, 8'hED};
        exp_mosi[0] = CMD;
        exp_mosi[1] = 8'h01;
        exp_mosi[2] = 8'h23;
        exp_mosi[3] = 8'h45;
        for (int i = 4; i < HDR + 4; i++) exp_mosi[i] = 8'h00;
        m0 = mon_cnt;
        d0 = done_tot;
        out_ready = 1'b1;
        pulse_start(24'h012345, 16'd4);
        wait_done(3000, ok);
        total++;
        if (!ok) $display("FAIL basic_done_timeout got=0 exp=1");
        else passes++;
        total++;
        if (spi_enabled !== 1'b0) $display("FAIL basic_cs_at_done got=%b exp=0", spi_enabled);
        else passes++;
        tick();
        total++;
        if (busy_out !== 1'b0) $display("FAIL basic_busy_after got=%b exp=0", busy_out);
        else passes++;
        total++;
        if (done_tot - d0 != 1) $display("FAIL basic_done_count got=%0d exp=1", done_tot - d0);
        else passes++;
        total++;
        if (mon_cnt - m0 != 4) $display("FAIL basic_byte_count got=%0d exp=4", mon_cnt - m0);
        else passes++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mon_log[(m0 + i) % 256] !== exp_out[i])
                $display("FAIL basic_out%0d got=%h exp=%h", i, mon_log[(m0 + i) % 256], exp_out[i]);
            else passes++;
        end
        for (int i = 0; i < HDR + 4; i++) begin
            total++;
            if (sess_log[i] !== exp_mosi[i])
                $display("FAIL basic_mosi%0d got=%h exp=%h", i, sess_log[i], exp_mosi[i]);
            else passes++;
        end
        $display("test_basic: bytes=%0d", mon_cnt - m0);
    endtask

    task automatic test_zero_len();
        int e0, lat;
        e0  = en_tot;
        lat = 0;
        pulse_start(24'h000100, 16'd0);
        for (int i = 1; i <= 6; i++) begin
            if (done) begin
                lat = i;
                break;
            end
            tick();
        end
        total++;
        if (lat < 1 || lat > 2) $display("FAIL zero_len_latency got=%0d exp=1..2", lat);
        else passes++;
        total++;
        if (busy_out !== 1'b1) $display("FAIL zero_len_busy_at_done got=%b exp=1", busy_out);
        else passes++;
        repeat (3) tick();
        total++;
        if (en_tot != e0) $display("FAIL zero_len_cs got=%0d exp=%0d", en_tot, e0);
        else passes++;
        $display("test_zero_len: latency=%0d", lat);
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_out [0:2];
        logic [7:0] held;
        int  m0, s0, bad;
        bit  ok, seen;
        exp_out = '{8'hA5, 8'hA4, 8'hA7};
        m0 = mon_cnt;
        out_ready = 1'b0;
        pulse_start(24'h000100, 16'd3);
        seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        total++;
        if (!seen) $display("FAIL stall_first_valid got=0 exp=1");
        else passes++;
        total++;
        if (out_data !== 8'hA5) $display("FAIL stall_first_byte got=%h exp=a5", out_data);
        else passes++;
        held = out_data;
        s0   = eng_starts;
        bad  = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (!out_valid || spi_busy || eng_starts != s0 || !spi_enabled || out_data !== held) bad++;
        end
        total++;
        if (bad != 0) $display("FAIL stall_hold got=%0d exp=0", bad);
        else passes++;
        out_ready = 1'b1;
        wait_done(3000, ok);
        tick();
        total++;
        if (!ok || mon_cnt - m0 != 3) $display("FAIL stall_count got=%0d exp=3", mon_cnt - m0);
        else passes++;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (mon_log[(m0 + i) % 256] !== exp_out[i])
                $display("FAIL stall_out%0d got=%h exp=%h", i, mon_log[(m0 + i) % 256], exp_out[i]);
            else passes++;
        end
        $display("test_backpressure: bytes=%0d", mon_cnt - m0);
    endtask

    task automatic test_mid_reset();
        int  m0, d0;
        bit  hit;
        m0 = mon_cnt;
        out_ready = 1'b1;
        pulse_start(24'h000010, 16'd4);
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (mon_cnt - m0 >= 1) begin
                hit = 1'b1;
                break;
            end
        end
        for (int i = 0; i < 50 && hit; i++) begin
            tick();
            if (spi_busy) break;
        end
        repeat (3) tick();
        total++;
        if (!hit || !spi_busy) $display("FAIL midrst_reach got=%b exp=1", spi_busy);
        else passes++;
        d0 = done_tot;
        reset = 1'b1;
        tick();
        total++;
        if ({spi_enabled, out_valid, busy_out, done} !== 4'b0000)
            $display("FAIL midrst_outputs got=%b exp=0000", {spi_enabled, out_valid, busy_out, done});
        else passes++;
        reset = 1'b0;
        repeat (5) tick();
        total++;
        if (done_tot != d0 || spi_enabled !== 1'b0)
            $display("FAIL midrst_no_done got=%0d exp=%0d", done_tot - d0, 0);
        else passes++;
        $display("test_mid_reset: done");
    endtask

    task automatic test_start_while_busy();
        int  m0;
        bit  ok;
        m0 = mon_cnt;
        out_ready = 1'b1;
        pulse_start(24'h000020, 16'd2);
        repeat (30) tick();
        pulse_start(24'hFFFFFF, 16'd7);
        wait_done(3000, ok);
        tick();
        total++;
        if (!ok || mon_cnt - m0 != 2) $display("FAIL busy_start_count got=%0d exp=2", mon_cnt - m0);
        else passes++;
        total++;
        if (mon_log[m0 % 256] !== 8'h85 || mon_log[(m0 + 1) % 256] !== 8'h84)
            $display("FAIL busy_start_data got=%h%h exp=8584", mon_log[m0 % 256], mon_log[(m0 + 1) % 256]);
        else passes++;
        total++;
        if ({sess_log[1], sess_log[2], sess_log[3]} !== 24'h000020)
            $display("FAIL busy_start_addr got=%h exp=000020", {sess_log[1], sess_log[2], sess_log[3]});
        else passes++;
        $display("test_start_while_busy: bytes=%0d", mon_cnt - m0);
    endtask

`ifdef FLASH_FAST_READ_EN
    task automatic test_fast_read();
        logic [7:0] exp_mosi [0:5];
        int  m0;
        bit  ok;
        exp_mosi = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        m0 = mon_cnt;
        out_ready = 1'b1;
        pulse_start(24'h000000, 16'd1);
        wait_done(3000, ok);
        tick();
        total++;
        if (!ok || mon_cnt - m0 != 1) $display("FAIL fast_count got=%0d exp=1", mon_cnt - m0);
        else passes++;
        total++;
        if (mon_log[m0 % 256] !== 8'hA5) $display("FAIL fast_data got=%h exp=a5", mon_log[m0 % 256]);
        else passes++;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (sess_log[i] !== exp_mosi[i])
                $display("FAIL fast_mosi%0d got=%h exp=%h", i, sess_log[i], exp_mosi[i]);
            else passes++;
        end
        $display("test_fast_read: bytes=%0d", mon_cnt - m0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_backpressure();
        test_mid_reset();
        test_start_while_busy();
`ifdef FLASH_FAST_READ_EN
        test_fast_read();
`endif
        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
